// File: rtl/branch_pkg.sv
// Shared types and constants for the execute-side branch resolve unit.
package branch_pkg;
    localparam int BTB_WAY_W   = 2;
    localparam int INSTR_BYTES = 4;
    localparam int BP_ADDR_W   = 64;

    typedef struct packed {
        logic [BP_ADDR_W-1:0] pc;
        logic                 taken;
        logic [BP_ADDR_W-1:0] target;
        logic [BTB_WAY_W-1:0] way;
    } bp_entry_t;
endpackage

// File: rtl/branch_resolve_pred_queue.sv
// In-order queue of fetch predictions awaiting resolution at execute.
module pred_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  bp_entry_t push_data,
    output bp_entry_t head,
    output logic      empty,
    output logic      ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    bp_entry_t          mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic               ready_r;
    logic               push_ok_s;
    logic               pop_ok_s;

    // ready_r mirrors !full, so a full queue refuses a push even while popping
    assign push_ok_s = push & ready_r & ~flush;
    assign pop_ok_s  = pop & (cnt_r != CNT_W'(0)) & ~flush;

    // Next occupancy
    always_comb begin
        cnt_next_s = cnt_r;
        if (flush) begin
            cnt_next_s = CNT_W'(0);
        end else if (push_ok_s && !pop_ok_s) begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            cnt_next_s = cnt_r - CNT_W'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Pointers, count and registered ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            cnt_r    <= CNT_W'(0);
            ready_r  <= 1'b0;
        end else begin
            cnt_r   <= cnt_next_s;
            ready_r <= (cnt_next_s != CNT_W'(DEPTH));
            if (flush) begin
                wr_ptr_r <= PTR_W'(0);
                rd_ptr_r <= PTR_W'(0);
            end else begin
                if (push_ok_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_ok_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
            end
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign empty = (cnt_r == CNT_W'(0));
    assign ready = ready_r;
endmodule

// File: rtl/branch_resolve_unit.sv
// Compares queued predictions with execute outcomes, updates the predictor and redirects fetch.
// Optional BRU_PERF_CNT_EN adds branch and mispredict counters.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_pred_valid,
    output logic                  o_pred_ready,
    input  logic [ADDR_WIDTH-1:0] i_pred_pc,
    input  logic                  i_pred_taken,
    input  logic [ADDR_WIDTH-1:0] i_pred_target,
    input  logic [BTB_WAY_W-1:0]  i_pred_way,
    input  logic                  i_flush,
    input  logic                  i_res_valid,
    input  logic                  i_res_is_branch,
    input  logic                  i_res_taken,
    input  logic [ADDR_WIDTH-1:0] i_res_pc,
    input  logic [ADDR_WIDTH-1:0] i_res_target,
    output logic                  o_branch_instr,
    output logic                  o_branch_taken,
    output logic [BTB_WAY_W-1:0]  o_way_write,
    output logic [ADDR_WIDTH-1:0] o_pc_exec,
    output logic [ADDR_WIDTH-1:0] o_pc_target_addr_exec,
    output logic                  o_mispredict,
    output logic [ADDR_WIDTH-1:0] o_redirect_pc,
`ifdef BRU_PERF_CNT_EN
    output logic                  o_err,
    output logic [31:0]           o_branch_cnt,
    output logic [31:0]           o_mispred_cnt
`else
    output logic                  o_err
`endif
);
    bp_entry_t             push_entry_s;
    bp_entry_t             head_s;
    logic                  empty_s;
    logic                  res_fire_s;
    logic                  act_taken_s;
    logic                  mis_s;
    logic                  err_set_s;
    logic [ADDR_WIDTH-1:0] redirect_s;

    logic                  branch_instr_r;
    logic                  branch_taken_r;
    logic [BTB_WAY_W-1:0]  way_write_r;
    logic [ADDR_WIDTH-1:0] pc_exec_r;
    logic [ADDR_WIDTH-1:0] target_r;
    logic                  mispredict_r;
    logic [ADDR_WIDTH-1:0] redirect_pc_r;
    logic                  err_r;

    // Pack the incoming prediction into a queue entry
    always_comb begin
        push_entry_s.pc     = BP_ADDR_W'(i_pred_pc);
        push_entry_s.taken  = i_pred_taken;
        push_entry_s.target = BP_ADDR_W'(i_pred_target);
        push_entry_s.way    = i_pred_way;
    end

    // A mispredict empties the queue at the same edge that pops the head
    pred_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (i_clk),
        .rst_n     (i_arst),
        .push      (i_pred_valid),
        .pop       (res_fire_s),
        .flush     (i_flush | mis_s),
        .push_data (push_entry_s),
        .head      (head_s),
        .empty     (empty_s),
        .ready     (o_pred_ready)
    );

    // A non-branch never counts as taken, so a BTB alias predicted taken mispredicts
    assign res_fire_s  = i_res_valid & ~empty_s;
    assign act_taken_s = i_res_is_branch & i_res_taken;
    assign mis_s       = res_fire_s &
                         ((head_s.taken != act_taken_s) |
                          (head_s.taken & act_taken_s &
                           (head_s.target[ADDR_WIDTH-1:0] != i_res_target)));
    assign err_set_s   = (i_res_valid & empty_s) |
                         (res_fire_s & (head_s.pc[ADDR_WIDTH-1:0] != i_res_pc));
    assign redirect_s  = act_taken_s ? i_res_target
                                     : i_res_pc + ADDR_WIDTH'(INSTR_BYTES);

    // Predictor update / redirect registers: strobes pulse, data holds
    always_ff @(posedge i_clk) begin
        if (!i_arst) begin
            branch_instr_r <= 1'b0;
            branch_taken_r <= 1'b0;
            way_write_r    <= BTB_WAY_W'(0);
            pc_exec_r      <= ADDR_WIDTH'(0);
            target_r       <= ADDR_WIDTH'(0);
            mispredict_r   <= 1'b0;
            redirect_pc_r  <= ADDR_WIDTH'(0);
            err_r          <= 1'b0;
        end else begin
            err_r <= err_r | err_set_s;
            if (res_fire_s) begin
                branch_instr_r <= i_res_is_branch;
                branch_taken_r <= i_res_taken;
                way_write_r    <= head_s.way;
                pc_exec_r      <= i_res_pc;
                target_r       <= i_res_target;
                mispredict_r   <= mis_s;
                redirect_pc_r  <= redirect_s;
            end else begin
                branch_instr_r <= 1'b0;
                mispredict_r   <= 1'b0;
            end
        end
    end

    assign o_branch_instr        = branch_instr_r;
    assign o_branch_taken        = branch_taken_r;
    assign o_way_write           = way_write_r;
    assign o_pc_exec             = pc_exec_r;
    assign o_pc_target_addr_exec = target_r;
    assign o_mispredict          = mispredict_r;
    assign o_redirect_pc         = redirect_pc_r;
    assign o_err                 = err_r;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] branch_cnt_r;
    logic [31:0] mispred_cnt_r;

    // Free-running performance counters, wrapping at 2^32
    always_ff @(posedge i_clk) begin
        if (!i_arst) begin
            branch_cnt_r  <= 32'd0;
            mispred_cnt_r <= 32'd0;
        end else begin
            if (res_fire_s && i_res_is_branch) begin
                branch_cnt_r <= branch_cnt_r + 32'd1;
            end
            if (mis_s) begin
                mispred_cnt_r <= mispred_cnt_r + 32'd1;
            end
        end
    end

    assign o_branch_cnt  = branch_cnt_r;
    assign o_mispred_cnt = mispred_cnt_r;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table plus hand-written queue corner cases.
module tb_branch_resolve_unit;
    logic        i_clk = 1'b0;
    logic        i_arst, i_pred_valid, o_pred_ready, i_pred_taken, i_flush;
    logic [63:0] i_pred_pc, i_pred_target, i_res_pc, i_res_target;
    logic [1:0]  i_pred_way, o_way_write;
    logic        i_res_valid, i_res_is_branch, i_res_taken;
    logic        o_branch_instr, o_branch_taken, o_mispredict, o_err;
    logic [63:0] o_pc_exec, o_pc_target_addr_exec, o_redirect_pc;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] o_branch_cnt, o_mispred_cnt;
`endif

    branch_resolve_unit #(.ADDR_WIDTH(64), .DEPTH(4)) dut (
        .i_clk(i_clk), .i_arst(i_arst), .i_pred_valid(i_pred_valid), .o_pred_ready(o_pred_ready),
        .i_pred_pc(i_pred_pc), .i_pred_taken(i_pred_taken), .i_pred_target(i_pred_target),
        .i_pred_way(i_pred_way), .i_flush(i_flush), .i_res_valid(i_res_valid),
        .i_res_is_branch(i_res_is_branch), .i_res_taken(i_res_taken), .i_res_pc(i_res_pc),
        .i_res_target(i_res_target), .o_branch_instr(o_branch_instr),
        .o_branch_taken(o_branch_taken), .o_way_write(o_way_write), .o_pc_exec(o_pc_exec),
        .o_pc_target_addr_exec(o_pc_target_addr_exec), .o_mispredict(o_mispredict),
        .o_redirect_pc(o_redirect_pc),
`ifdef BRU_PERF_CNT_EN
        .o_err(o_err), .o_branch_cnt(o_branch_cnt), .o_mispred_cnt(o_mispred_cnt)
`else
        .o_err(o_err)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        br, tk, chk_data, mis;
        logic [1:0]  way;
        logic [63:0] redir, pc, tgt;
    } exp_t;

    typedef struct {
        logic [63:0] ppc; logic ptk; logic [63:0] ptgt; logic [1:0] pway;
        logic br; logic rtk; logic [63:0] rtgt;
        logic exp_mis; logic [63:0] exp_redir;
    } vec_t;

    typedef struct {
        logic [63:0] pc; logic tk; logic [63:0] tgt; logic [1:0] way;
    } ment_t;

    int    checks = 0;
    int    errors = 0;
    exp_t  exp_q[$];
    ment_t mq[$];
    vec_t  vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_arst = 1'b0; i_pred_valid = 1'b0; i_flush = 1'b0; i_res_valid = 1'b0;
        i_pred_pc = 64'd0; i_pred_taken = 1'b0; i_pred_target = 64'd0; i_pred_way = 2'd0;
        i_res_is_branch = 1'b0; i_res_taken = 1'b0; i_res_pc = 64'd0; i_res_target = 64'd0;
        tick();
        tick();
        i_arst = 1'b1;
        tick();
        mq.delete();
    endtask

    task automatic set_push(input logic [63:0] pc, input logic tk, input logic [63:0] tgt,
                            input logic [1:0] way);
        i_pred_valid = 1'b1; i_pred_pc = pc; i_pred_taken = tk;
        i_pred_target = tgt; i_pred_way = way;
    endtask

    task automatic do_push(input logic [63:0] pc, input logic tk, input logic [63:0] tgt,
                           input logic [1:0] way);
        set_push(pc, tk, tgt, way);
        tick();
        i_pred_valid = 1'b0;
    endtask

    function automatic exp_t mk_exp(input logic br, input logic tk, input logic [1:0] way,
                                    input logic mis, input logic [63:0] redir,
                                    input logic [63:0] pc, input logic [63:0] tgt);
        exp_t e;
        e.br = br; e.tk = tk; e.chk_data = 1'b1; e.way = way; e.mis = mis;
        e.redir = redir; e.pc = pc; e.tgt = tgt;
        return e;
    endfunction

    // Drives one resolve (any pending push stays in the same cycle) and checks the N+1 outputs
    task automatic do_resolve(input string name, input logic br, input logic tk,
                              input logic [63:0] pc, input logic [63:0] tgt, input exp_t e);
        exp_t x;
        i_res_valid = 1'b1; i_res_is_branch = br; i_res_taken = tk;
        i_res_pc = pc; i_res_target = tgt;
        exp_q.push_back(e);
        tick();
        i_res_valid = 1'b0; i_pred_valid = 1'b0; i_flush = 1'b0;
        if (exp_q.size() == 0) begin
            chk({name, " scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            x = exp_q.pop_front();
            chk({name, " branch_instr"}, {63'd0, o_branch_instr}, {63'd0, x.br});
            chk({name, " mispredict"}, {63'd0, o_mispredict}, {63'd0, x.mis});
            if (x.chk_data) begin
                chk({name, " branch_taken"}, {63'd0, o_branch_taken}, {63'd0, x.tk});
                chk({name, " way_write"}, {62'd0, o_way_write}, {62'd0, x.way});
                chk({name, " redirect_pc"}, o_redirect_pc, x.redir);
                chk({name, " pc_exec"}, o_pc_exec, x.pc);
                chk({name, " target_exec"}, o_pc_target_addr_exec, x.tgt);
            end
        end
    endtask

    task automatic resolve_model(input string name);
        ment_t m;
        logic [63:0] tgt;
        m = mq.pop_front();
        tgt = m.tk ? m.tgt : {32'd0, $urandom};
        do_resolve(name, 1'b1, m.tk, m.pc, tgt,
                   mk_exp(1'b1, m.tk, m.way, 1'b0, m.tk ? tgt : m.pc + 64'd4, m.pc, tgt));
    endtask

    initial begin
        vecs[0] = '{64'h100, 1'b0, 64'h0,   2'd2, 1'b1, 1'b0, 64'h200, 1'b0, 64'h104};
        vecs[1] = '{64'h300, 1'b1, 64'h500, 2'd3, 1'b0, 1'b0, 64'h0,   1'b1, 64'h304};
        vecs[2] = '{64'h400, 1'b1, 64'h800, 2'd1, 1'b1, 1'b1, 64'h800, 1'b0, 64'h800};
        vecs[3] = '{64'h500, 1'b1, 64'h900, 2'd0, 1'b1, 1'b1, 64'h904, 1'b1, 64'h904};
        vecs[4] = '{64'h600, 1'b1, 64'hA00, 2'd2, 1'b1, 1'b0, 64'hA00, 1'b1, 64'h604};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 2'd1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0};
        vecs[6] = '{64'h700, 1'b0, 64'h0,   2'd3, 1'b1, 1'b1, 64'h40,  1'b1, 64'h40};
        vecs[7] = '{64'h800, 1'b0, 64'h0,   2'd0, 1'b0, 1'b1, 64'h44,  1'b0, 64'h804};

        // Reset state
        i_arst = 1'b0; i_pred_valid = 1'b0; i_flush = 1'b0; i_res_valid = 1'b0;
        i_pred_pc = 64'd0; i_pred_taken = 1'b0; i_pred_target = 64'd0; i_pred_way = 2'd0;
        i_res_is_branch = 1'b0; i_res_taken = 1'b0; i_res_pc = 64'd0; i_res_target = 64'd0;
        tick();
        tick();
        chk("rst ready", {63'd0, o_pred_ready}, 64'd0);
        chk("rst branch_instr", {63'd0, o_branch_instr}, 64'd0);
        chk("rst mispredict", {63'd0, o_mispredict}, 64'd0);
        chk("rst redirect", o_redirect_pc, 64'd0);
        chk("rst way", {62'd0, o_way_write}, 64'd0);
        chk("rst err", {63'd0, o_err}, 64'd0);
        i_arst = 1'b1;
        tick();
        chk("post-rst ready", {63'd0, o_pred_ready}, 64'd1);

        // Single push/resolve vectors
        for (int i = 0; i < 8; i++) begin
            do_push(vecs[i].ppc, vecs[i].ptk, vecs[i].ptgt, vecs[i].pway);
            do_resolve($sformatf("vec%0d", i), vecs[i].br, vecs[i].rtk, vecs[i].ppc,
                       vecs[i].rtgt, mk_exp(vecs[i].br, vecs[i].rtk, vecs[i].pway,
                       vecs[i].exp_mis, vecs[i].exp_redir, vecs[i].ppc, vecs[i].rtgt));
            tick();
            chk($sformatf("vec%0d strobe_clear", i), {62'd0, o_branch_instr, o_mispredict}, 64'd0);
        end
        chk("vec err", {63'd0, o_err}, 64'd0);

        // Push in the mispredict cycle is dropped
        do_push(64'h10, 1'b1, 64'h80, 2'd0);
        set_push(64'h20, 1'b1, 64'h999, 2'd1);
        do_resolve("mis_drop", 1'b1, 1'b1, 64'h10, 64'h90,
                   mk_exp(1'b1, 1'b1, 2'd0, 1'b1, 64'h90, 64'h10, 64'h90));
        do_push(64'h30, 1'b0, 64'h0, 2'd2);
        do_resolve("after_mis", 1'b1, 1'b0, 64'h30, 64'h0,
                   mk_exp(1'b1, 1'b0, 2'd2, 1'b0, 64'h34, 64'h30, 64'h0));
        chk("mis_drop err", {63'd0, o_err}, 64'd0);

        // External flush: resolve still evaluated, same-cycle push dropped
        do_push(64'h50, 1'b1, 64'h60, 2'd1);
        do_push(64'h54, 1'b1, 64'h70, 2'd3);
        i_flush = 1'b1;
        set_push(64'h58, 1'b1, 64'h99, 2'd0);
        do_resolve("flush_res", 1'b1, 1'b1, 64'h50, 64'h60,
                   mk_exp(1'b1, 1'b1, 2'd1, 1'b0, 64'h60, 64'h50, 64'h60));
        do_push(64'h5c, 1'b0, 64'h0, 2'd2);
        do_resolve("after_flush", 1'b0, 1'b0, 64'h5c, 64'h0,
                   mk_exp(1'b0, 1'b0, 2'd2, 1'b0, 64'h60, 64'h5c, 64'h0));
        chk("flush err", {63'd0, o_err}, 64'd0);

        // Full queue, refused push during pop, then wrap-around order
        for (int i = 0; i < 4; i++) begin
            mq.push_back('{64'h1000 + 64'(4 * i), 1'b0, 64'h0, 2'(i)});
            do_push(64'h1000 + 64'(4 * i), 1'b0, 64'h0, 2'(i));
        end
        chk("full ready", {63'd0, o_pred_ready}, 64'd0);
        set_push(64'h2000, 1'b1, 64'h2222, 2'd3);
        resolve_model("full_pop");
        chk("after refused ready", {63'd0, o_pred_ready}, 64'd1);
        mq.push_back('{64'h3000, 1'b0, 64'h0, 2'd1});
        do_push(64'h3000, 1'b0, 64'h0, 2'd1);
        chk("count3 refill ready", {63'd0, o_pred_ready}, 64'd0);
        for (int i = 0; i < 12; i++) begin
            ment_t m;
            resolve_model($sformatf("wrap%0d", i));
            chk($sformatf("wrap%0d ready", i), {63'd0, o_pred_ready}, 64'd1);
            m.pc = 64'h4000 + 64'(16 * i); m.tk = 1'($urandom);
            m.tgt = {32'd0, $urandom}; m.way = 2'($urandom);
            mq.push_back(m);
            do_push(m.pc, m.tk, m.tgt, m.way);
        end
        while (mq.size() > 0) resolve_model("drain");
        chk("wrap err", {63'd0, o_err}, 64'd0);

        // Mispredict discards younger entries; next resolve underflows
        do_push(64'h200, 1'b0, 64'h0, 2'd1);
        do_push(64'h204, 1'b0, 64'h0, 2'd2);
        do_push(64'h208, 1'b0, 64'h0, 2'd3);
        do_resolve("mis_flush", 1'b1, 1'b1, 64'h200, 64'h400,
                   mk_exp(1'b1, 1'b1, 2'd1, 1'b1, 64'h400, 64'h200, 64'h400));
        chk("mis_flush ready", {63'd0, o_pred_ready}, 64'd1);
        begin
            exp_t u;
            u = mk_exp(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 64'd0);
            u.chk_data = 1'b0;
            do_resolve("underflow", 1'b1, 1'b0, 64'h204, 64'h0, u);
        end
        chk("underflow err", {63'd0, o_err}, 64'd1);

        // PC mismatch sets a sticky error; reset clears it
        do_reset();
        chk("reset clears err", {63'd0, o_err}, 64'd0);
        do_push(64'h100, 1'b0, 64'h0, 2'd1);
        do_resolve("pc_mismatch", 1'b1, 1'b0, 64'h104, 64'h0,
                   mk_exp(1'b1, 1'b0, 2'd1, 1'b0, 64'h108, 64'h104, 64'h0));
        chk("pc err", {63'd0, o_err}, 64'd1);
        tick();
        tick();
        chk("pc err sticky", {63'd0, o_err}, 64'd1);

`ifdef BRU_PERF_CNT_EN
        begin
            int n_br = 0;
            int n_mis = 0;
            do_reset();
            for (int i = 0; i < 100; i++) begin
                logic [63:0] pc, pt, rt;
                logic ptk, br, rtk, act, mis;
                logic [1:0] way;
                pc = {32'd0, $urandom} & 64'hFFFF_FFFC;
                ptk = 1'($urandom); br = 1'($urandom); rtk = 1'($urandom);
                pt = $urandom_range(1) ? 64'hA0 : 64'hB0;
                rt = $urandom_range(1) ? 64'hA0 : 64'hB0;
                way = 2'($urandom);
                act = br & rtk;
                mis = (ptk != act) | (ptk & act & (pt != rt));
                if (br) n_br++;
                if (mis) n_mis++;
                do_push(pc, ptk, pt, way);
                do_resolve("perf", br, rtk, pc, rt,
                           mk_exp(br, rtk, way, mis, act ? rt : pc + 64'd4, pc, rt));
            end
            chk("branch_cnt", {32'd0, o_branch_cnt}, 64'(n_br));
            chk("mispred_cnt", {32'd0, o_mispred_cnt}, 64'(n_mis));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-side counterpart of the fetch-stage branch predictor.
- Holds the prediction made for every fetched instruction in an in-order queue, then compares each prediction with the real outcome at execute.
- Drives the predictor's BTB/BHT update bus.
- Raises a registered mispredict/redirect to fetch and discards all younger in-flight predictions.

Parameters:
- ADDR_WIDTH, 64, PC/target width.
- DEPTH, 4, in-flight prediction queue entries; power of two, at least 2.

Ports:
- i_clk  in  1  clock.
- i_arst  in  1  reset; synchronous, active-low.
- i_pred_valid  in  1  fetch pushes one prediction.
- o_pred_ready  out  1  queue not full.
- i_pred_pc  in  ADDR_WIDTH  fetched PC.
- i_pred_taken  in  1  predictor said taken.
- i_pred_target  in  ADDR_WIDTH  predicted target.
- i_pred_way  in  2  BTB way returned with the prediction.
- i_flush  in  1  external flush (exception/trap); empties queue.
- i_res_valid  in  1  execute resolves the oldest instruction.
- i_res_is_branch  in  1  resolved instruction is a branch/jump.
- i_res_taken  in  1  actual direction.
- i_res_pc  in  ADDR_WIDTH  PC of resolved instruction.
- i_res_target  in  ADDR_WIDTH  actual target.
- o_branch_instr  out  1  predictor update strobe.
- o_branch_taken  out  1  update direction.
- o_way_write  out  2  BTB way to write.
- o_pc_exec  out  ADDR_WIDTH  update PC.
- o_pc_target_addr_exec  out  ADDR_WIDTH  update target.
- o_mispredict  out  1  one-cycle redirect pulse.
- o_redirect_pc  out  ADDR_WIDTH  fetch restart PC.
- o_err  out  1  sticky protocol error.

Behaviour:
- Reset (i_arst=0 at a clk edge): queue empty, pointers 0, all outputs 0.
  - o_pred_ready is 0 while i_arst=0 and 1 from the first cycle after release.
- Queue: circular FIFO with DEPTH entries {pc, taken, target, way}, plus an occupancy count of width $clog2(DEPTH)+1.
  - Push when i_pred_valid & o_pred_ready.
  - o_pred_ready = !full. A push is refused when full, even if a pop happens in the same cycle.
  - Pointers wrap modulo DEPTH.
- Resolve (cycle N, i_res_valid=1, queue non-empty): pop the head entry.
  - mis = (head.taken != act_taken) | (head.taken & act_taken & head.target != i_res_target).
  - act_taken = i_res_is_branch & i_res_taken.
  - A non-branch predicted taken (BTB alias) therefore mispredicts.
- Outputs are registered and valid in cycle N+1 for exactly one cycle:
  - o_branch_instr = i_res_is_branch.
  - o_branch_taken = i_res_taken.
  - o_pc_exec = i_res_pc.
  - o_pc_target_addr_exec = i_res_target.
  - o_way_write = head.way.
  - o_mispredict = mis.
  - o_redirect_pc = act_taken ? i_res_target : i_res_pc + 4, computed modulo 2^ADDR_WIDTH so that PC+4 wraps.
  - Without a resolve, all strobes return to 0 and the data outputs hold their last values.
- Mispredict flush: at the edge ending cycle N the queue is emptied.
  - A push attempted in cycle N is dropped.
  - Pushes in cycle N+1 are accepted; fetch is already redirected.
- PC check: if head.pc != i_res_pc on resolve, set o_err (sticky until reset). The resolve still proceeds as above.
- Underflow: i_res_valid with an empty queue sets o_err. There is no pop, no update strobe and no mispredict.
- i_flush: empties the queue at the edge; a same-cycle push is dropped.
  - A resolve in the same cycle is still evaluated against the head and produces its outputs.
  - i_flush has priority over push.
- Reset mid-operation discards all entries and any pending output pulse.

Optional Feature:
- BRU_PERF_CNT_EN. When defined, adds two outputs:
  - o_branch_cnt [31:0]: increments on each resolve with i_res_is_branch=1.
  - o_mispred_cnt [31:0]: increments on each mispredict.
  - Both reset to 0 and wrap at 2^32.
- When undefined, neither port nor counter logic exists.

Decomposition:
- Package branch_pkg holds:
  - typedef bp_entry_t {pc, taken, target, way[1:0]}.
  - localparam BTB_WAY_W = 2.
  - localparam INSTR_BYTES = 4.
- Sub-module pred_queue: parameterised FIFO with push/pop/flush, full/empty and head data.
- The compare/redirect logic and output registers stay in branch_resolve_unit.

Test Plan:
1. Reset, then push pc=0x100 taken=0. Resolve with is_branch=1, taken=0 → next cycle o_branch_instr=1, o_mispredict=0, o_way_write equals the pushed way.
2. Push pc=0x200 taken=0. Resolve taken=1, target=0x400 → o_mispredict=1, o_redirect_pc=0x400; the two other queued entries are gone (o_pred_ready=1, a following resolve sets o_err).
3. Push pc=0x300 taken=1 target=0x500. Resolve is_branch=0 → o_mispredict=1, o_redirect_pc=0x304, o_branch_instr=0.
4. Push pc=0x10 taken=1 target=0x80. Resolve taken=1 target=0x90 → mispredict, redirect 0x90; the push in the same cycle is dropped.
5. Push 4 entries → o_pred_ready=0. A fifth push plus a simultaneous pop: the fifth push is not accepted and the count is 3. Push/pop through 3 full wraps: head order is preserved and o_err stays 0.
6. Resolve with res_pc=0x104 while head.pc=0x100 → o_err=1 and it stays 1. With BRU_PERF_CNT_EN, the counters match the scoreboard after 100 random resolves.
